// File: rtl/decode_stage.sv
// Registered instruction-decode stage: opcode decode, operand capture, scoreboard-based
// RAW/WAW stall, valid/ready handshake toward fetch and execute, saturating stall counter.
module decode_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 5,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_AW-1:0]  rf_raddr1,
    output logic [REG_AW-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         alu_op,
    output logic               reg_write,
    output logic [REG_AW-1:0]  rd,
    output logic [DATA_W-1:0]  a,
    output logic [DATA_W-1:0]  b,
    output logic               illegal,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int NREG = 1 << REG_AW;

    typedef struct packed {
        logic       legal;
        logic       reg_write;
        logic [2:0] alu_op;
    } dec_t;

    // Opcode table; anything outside it is illegal and writes nothing.
    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        case (op)
            6'd0:    d = '{legal: 1'b1, reg_write: 1'b1, alu_op: 3'b001};
            6'd1:    d = '{legal: 1'b1, reg_write: 1'b1, alu_op: 3'b010};
            6'd2:    d = '{legal: 1'b1, reg_write: 1'b1, alu_op: 3'b011};
            6'd3:    d = '{legal: 1'b1, reg_write: 1'b1, alu_op: 3'b100};
            6'd4:    d = '{legal: 1'b1, reg_write: 1'b1, alu_op: 3'b101};
            6'd5:    d = '{legal: 1'b1, reg_write: 1'b1, alu_op: 3'b110};
            default: d = '{legal: 1'b0, reg_write: 1'b0, alu_op: 3'b000};
        endcase
        return d;
    endfunction

    logic [5:0]        opcode_s;
    logic [REG_AW-1:0] rs1_s;
    logic [REG_AW-1:0] rs2_s;
    logic [REG_AW-1:0] rd_s;
    dec_t              dec_s;
    logic              hazard_s;
    logic              accept_s;
    logic              stall_s;
    logic [NREG-1:0]   pend_r;
    logic [NREG-1:0]   pend_next_s;

    logic              out_valid_r;
    logic [2:0]        alu_op_r;
    logic              reg_write_r;
    logic [REG_AW-1:0] rd_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              illegal_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              in_ready_s;

    // Field extraction and handshake qualification.
    always_comb begin
        opcode_s = instr[INSTR_W-1 -: 6];
        rs1_s    = instr[REG_AW-1:0];
        rs2_s    = instr[2*REG_AW-1:REG_AW];
        rd_s     = instr[3*REG_AW-1:2*REG_AW];
        dec_s    = decode_op(opcode_s);
        // Only the registered scoreboard is consulted: no forwarding of same-cycle writebacks.
        hazard_s = in_valid & (pend_r[rs1_s] | pend_r[rs2_s] | (dec_s.legal & pend_r[rd_s]));
        in_ready_s = ~reset & ~hazard_s & (~out_valid_r | out_ready);
        accept_s   = in_valid & in_ready_s;
        stall_s    = in_valid & ~in_ready_s & ~reset;
    end

    // Scoreboard next state: clear on writeback, then set on accept so a set wins.
    always_comb begin
        pend_next_s = pend_r;
        if (wb_en) begin
            pend_next_s[wb_addr] = 1'b0;
        end else begin
            pend_next_s = pend_next_s;
        end
        if (accept_s && dec_s.reg_write) begin
            pend_next_s[rd_s] = 1'b1;
        end else begin
            pend_next_s = pend_next_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_next_s;
        end
    end

    // Output pipeline register: load on accept, drop valid on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            alu_op_r    <= 3'b000;
            reg_write_r <= 1'b0;
            rd_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            illegal_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            alu_op_r    <= dec_s.alu_op;
            reg_write_r <= dec_s.reg_write;
            rd_r        <= rd_s;
            a_r         <= rf_rdata1;
            b_r         <= rf_rdata2;
            illegal_r   <= ~dec_s.legal;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of cycles where fetch offered an instruction that was refused.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign rf_raddr1 = rs1_s;
    assign rf_raddr2 = rs2_s;
    assign out_valid = out_valid_r;
    assign alu_op    = alu_op_r;
    assign reg_write = reg_write_r;
    assign rd        = rd_r;
    assign a         = a_r;
    assign b         = b_r;
    assign illegal   = illegal_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: reset, decode, RAW stall, backpressure,
// illegal opcode and mid-operation reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_op;
    logic        reg_write;
    logic [4:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic        illegal;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    decode_stage #(.DATA_W(16), .REG_AW(5), .INSTR_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .reg_write(reg_write), .rd(rd), .a(a), .b(b), .illegal(illegal),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d,
                                       input logic [4:0] s2, input logic [4:0] s1);
        return {op, 11'd0, d, s2, s1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; instr = mk(6'd0, 5'd3, 5'd2, 5'd1);
        rf_rdata1 = 16'h0005; rf_rdata2 = 16'h0007; wb_en = 1'b0; wb_addr = 5'd0; out_ready = 1'b1;

        // 1. reset held two cycles with in_valid high
        tick; tick;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // 2. single add r3 = r1 + r2
        reset = 1'b0;
        #1;
        chk("add_in_ready", 32'(in_ready), 32'd1);
        chk("add_raddr1", 32'(rf_raddr1), 32'd1);
        chk("add_raddr2", 32'(rf_raddr2), 32'd2);
        tick;
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_alu_op", 32'(alu_op), 32'd1);
        chk("add_reg_write", 32'(reg_write), 32'd1);
        chk("add_rd", 32'(rd), 32'd3);
        chk("add_a", 32'(a), 32'h0005);
        chk("add_b", 32'(b), 32'h0007);

        // 3. sub reading r3 stalls until the cycle after wb of r3
        instr = mk(6'd1, 5'd4, 5'd0, 5'd3);
        rf_rdata1 = 16'h0011; rf_rdata2 = 16'h0022;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("raw_stall", 32'(in_ready), 32'd0);
            tick;
        end
        chk("raw_drained", 32'(out_valid), 32'd0);
        chk("raw_rd_hold", 32'(rd), 32'd3);
        wb_en = 1'b1; wb_addr = 5'd3;
        #1;
        chk("raw_wb_cycle", 32'(in_ready), 32'd0);
        tick;
        wb_en = 1'b0;
        #1;
        chk("raw_released", 32'(in_ready), 32'd1);
        chk("raw_stall_cnt", 32'(stall_cnt), 32'd4);
        tick;
        chk("sub_out_valid", 32'(out_valid), 32'd1);
        chk("sub_alu_op", 32'(alu_op), 32'd2);
        chk("sub_rd", 32'(rd), 32'd4);
        chk("sub_a", 32'(a), 32'h0011);

        // 4. backpressure with two independent ops
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd4;
        tick;
        wb_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        instr = mk(6'd2, 5'd5, 5'd6, 5'd7);
        rf_rdata1 = 16'hAAAA; rf_rdata2 = 16'h5555;
        #1;
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        tick;
        instr = mk(6'd3, 5'd8, 5'd9, 5'd10);
        rf_rdata1 = 16'h1234; rf_rdata2 = 16'h4321;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_refuse", 32'(in_ready), 32'd0);
            tick;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_rd", 32'(rd), 32'd5);
            chk("bp_hold_a", 32'(a), 32'hAAAA);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_b_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        chk("bp_b_alu_op", 32'(alu_op), 32'd4);
        chk("bp_b_rd", 32'(rd), 32'd8);
        chk("bp_b_a", 32'(a), 32'h1234);
        chk("bp_b_b", 32'(b), 32'h4321);
        tick;
        chk("bp_drain", 32'(out_valid), 32'd0);
        chk("bp_drain_rd", 32'(rd), 32'd8);
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd7);

        // 5. illegal opcode; its rd field must not be checked or marked
        in_valid = 1'b1;
        instr = mk(6'h3F, 5'd5, 5'd11, 5'd12);
        #1;
        chk("ill_no_rd_hazard", 32'(in_ready), 32'd1);
        tick;
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_alu_op", 32'(alu_op), 32'd0);
        chk("ill_reg_write", 32'(reg_write), 32'd0);
        instr = mk(6'h3F, 5'd13, 5'd11, 5'd12);
        tick;
        instr = mk(6'd4, 5'd13, 5'd14, 5'd15);
        #1;
        chk("ill_next_ready", 32'(in_ready), 32'd1);
        tick;
        chk("xor_alu_op", 32'(alu_op), 32'd5);
        chk("xor_illegal", 32'(illegal), 32'd0);
        chk("xor_rd", 32'(rd), 32'd13);

        // 6. reset with r3 pending and an op held
        instr = mk(6'd0, 5'd3, 5'd1, 5'd2);
        tick;
        chk("pre_rst_rd", 32'(rd), 32'd3);
        in_valid = 1'b0; reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        tick;
        reset = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_rd", 32'(rd), 32'd0);
        in_valid = 1'b1;
        instr = mk(6'd5, 5'd6, 5'd3, 5'd3);
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        chk("slt_valid", 32'(out_valid), 32'd1);
        chk("slt_alu_op", 32'(alu_op), 32'd6);
        chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
